// File: rtl/countdown_pkg.sv
// Shared constants for the countdown timer: FSM encoding and prescaler width.
package countdown_pkg;

    // Prescaler counter width; supports PRESCALE values up to 255.
    localparam int PRESC_W = 8;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A countdown is in progress (running or paused).
    function automatic logic is_active(logic [1:0] s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/countdown_timer_tick_divider.sv
// Prescaler: issues one tick every PRESCALE cycles while run is high.
// The phase is held whenever run is low, so a pause resumes mid-period.
module tick_divider
    import countdown_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [PRESC_W-1:0] ONE  = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    // Terminal phase detect and next phase.
    always_comb begin
        tick    = run && (presc_q == LAST);
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = tick ? '0 : presc_q + ONE;
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, pause, abort and optional periodic reload.
//
// state | meaning
// IDLE  | waiting for a load; count is 0 or was loaded with 0
// RUN   | counting down, one step per prescaler tick
// PAUSE | enable low; count and prescaler phase held
// DONE  | reached terminal count without reload; count held at 0
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    input  logic                  enable,
    input  logic                  stop,
    input  logic                  auto_reload,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  busy,
    output logic                  done,
    output logic                  expire
);

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state_q,  state_d;
    logic [DATA_WIDTH-1:0] count_q,  count_d;
    logic [DATA_WIDTH-1:0] reload_q, reload_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  expire_q, expire_d;
    logic                  presc_clear;
    logic                  presc_run;
    logic                  tick;

    // The prescaler only advances in RUN; it restarts on load/stop and rests in IDLE/DONE.
    assign presc_clear = load || stop || (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign presc_run   = (state_q == ST_RUN) && enable;

    tick_divider #(
        .PRESCALE (PRESCALE)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .run   (presc_run),
        .tick  (tick)
    );

    // Next-state logic: stop beats load, load beats any terminal tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!enable) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else begin
                            expire_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (enable) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = is_active(state_d);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            expire_q <= expire_d;
        end
    end

    assign count  = count_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign expire = expire_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, giving the count/load width in bits.
REQ-002 SHALL have parameter PRESCALE, default 1, giving clock cycles per decrement tick (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port load  input  1  one-cycle strobe that starts or restarts the countdown from load_val.
REQ-006 SHALL have port load_val  input  DATA_WIDTH  start value, captured only when load=1.
REQ-007 SHALL have port enable  input  1  level gate; low pauses the countdown without losing count.
REQ-008 SHALL have port stop  input  1  one-cycle strobe that aborts the countdown.
REQ-009 SHALL have port auto_reload  input  1  level; high makes the timer periodic.
REQ-010 SHALL have port count  output  DATA_WIDTH  current remaining count, registered.
REQ-011 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-012 SHALL have port done  output  1  level, high in DONE.
REQ-013 SHALL have port expire  output  1  one-cycle pulse on each terminal count, registered.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-015 On load=1 with stop=0, SHALL set count and an internal reload register to load_val and clear the prescaler, from any state, at the next edge.
REQ-016 On that load, SHALL enter RUN if load_val is nonzero; with load_val=0, SHALL enter IDLE with no expire pulse.
REQ-017 On stop=1, SHALL enter IDLE and clear count to 0 at the next edge; stop SHALL win over a simultaneous load.
REQ-018 In RUN with enable=1, SHALL advance the prescaler each cycle and issue a tick every PRESCALE cycles; PRESCALE=1 SHALL tick every cycle.
REQ-019 On each tick with count>1, SHALL decrement count by 1.
REQ-020 On a tick with count==1 and auto_reload=0, SHALL set count to 0, pulse expire for exactly one cycle, and enter DONE.
REQ-021 On a tick with count==1 and auto_reload=1, SHALL set count to the reload register, pulse expire for one cycle, and stay in RUN (period = reload × PRESCALE cycles).
REQ-022 In RUN with enable=0, SHALL enter PAUSE, holding count and prescaler; in PAUSE, enable=1 SHALL return to RUN and resume from the held prescaler phase.
REQ-023 In DONE, count SHALL hold 0 and done SHALL stay high until load or stop.
REQ-024 The decrement SHALL never wrap below 0.
REQ-025 A load coinciding with a terminal tick SHALL take priority: no expire pulse, count = load_val.
REQ-026 In IDLE or DONE, the prescaler SHALL be held at 0.
REQ-027 Latency: a load at edge k SHALL show count=load_val after edge k; with PRESCALE=1 and enable held high, count SHALL reach 0 and expire SHALL go high after edge k+load_val.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, count=0, reload register=0, prescaler=0, busy=0, done=0 and expire=0, independent of clk.
REQ-029 Reset assertion mid-countdown SHALL discard all progress; after release, the block SHALL wait in IDLE for a load.

Structure
REQ-030 The state encoding (IDLE/RUN/PAUSE/DONE) and the prescaler counter width constant (8 bits) SHALL live in a shared package, countdown_pkg.
REQ-031 The prescaler SHALL be a single sub-module, tick_divider, with inputs clk, reset, clear and run, output tick, and parameter PRESCALE.
REQ-032 All outputs SHALL be driven directly from flops, with no combinational paths from input to output.

Verification (DATA_WIDTH=5, PRESCALE=1 unless stated)
REQ-033 Load 5 with enable=1 and auto_reload=0: count SHALL go 5,4,3,2,1,0, expire SHALL be high for exactly the one cycle in which count=0, and done SHALL go high and stay high.
REQ-034 Load 3 with auto_reload=1 and 10 cycles run: count SHALL go 3,2,1,3,2,1,3,…, with expire pulsing every 3 cycles and busy held high.
REQ-035 Load 6, then drop enable for 4 cycles while count=4: count SHALL hold at 4 and busy SHALL stay 1; on re-enable, 4,3,2,1,0 SHALL follow with a single expire.
REQ-036 Load 31 followed by stop and load in the same cycle: the block SHALL enter IDLE with count=0; a load of 0 SHALL leave the block in IDLE with no expire.
REQ-037 PRESCALE=4, load 2: expire SHALL occur 8 cycles after the load edge; driving reset low at count=1 SHALL drive all outputs to 0 asynchronously.
